// File: rtl/instr_mem_pkg.sv
// instr_mem_pkg: shared definitions for the instruction memory loader.
//   state_t            loader FSM encoding, also driven on o_state
//   HALT_WORD_DEFAULT  default end-of-program marker
//   BYTE_W             width of one serial-link byte
package instr_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    LOADED = 2'd2,
    RUN    = 2'd3
  } state_t;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
  localparam int unsigned BYTE_W            = 8;

endpackage

// File: rtl/byte_word_assembler.sv
// byte_word_assembler: packs serial-link bytes into little-endian words.
// The first byte of a word lands in bits 7:0. When the last byte of a word
// is accepted, the full word is registered and o_word_valid pulses for one
// cycle starting on the following cycle.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_clear        drop any partial word and restart at byte 0
//   i_byte_valid   accept i_byte this cycle
//   i_byte         incoming byte
//   o_word         last completed word (held until the next one)
//   o_word_valid   one-cycle pulse when o_word is freshly completed
module byte_word_assembler
  import instr_mem_pkg::*;
#(
  parameter int unsigned NB_DATA_BUS = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clear,
  input  logic                   i_byte_valid,
  input  logic [BYTE_W-1:0]      i_byte,
  output logic [NB_DATA_BUS-1:0] o_word,
  output logic                   o_word_valid
);

  localparam int unsigned N_BYTES = NB_DATA_BUS / BYTE_W;
  localparam int unsigned NB_IDX  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(N_BYTES - 1);

  logic [NB_IDX-1:0]      r_idx;
  logic [NB_DATA_BUS-1:0] r_shift;
  logic [NB_DATA_BUS-1:0] r_word;
  logic                   r_word_valid;
  logic [NB_DATA_BUS-1:0] w_shift_next;

  // New bytes enter at the top and move down, so after N_BYTES shifts the
  // first byte sits in the least significant lane.
  assign w_shift_next = {i_byte, r_shift[NB_DATA_BUS-1:BYTE_W]};

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_idx        <= '0;
      r_shift      <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      if (i_byte_valid) begin
        r_shift <= w_shift_next;
        if (r_idx == LAST_IDX) begin
          r_idx        <= '0;
          r_word       <= w_shift_next;
          r_word_valid <= 1'b1;
        end else begin
          r_idx <= r_idx + NB_IDX'(1);
        end
      end
    end
  end

  assign o_word       = r_word;
  assign o_word_valid = r_word_valid;

endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: loads a program from the debug serial link into the
// instruction memory, then releases the CPU to fetch from it.
// Optional feature macro: INSTR_MEM_LOADER_CHECKSUM_EN adds o_checksum,
// the XOR of every word written during the current load.
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_load_start              pulse: (re)start a program load
//   i_run                     pulse: release CPU fetch once loaded
//   i_rx_data, i_rx_valid     program byte stream
//   i_cpu_addr, i_cpu_r_en    CPU fetch request
//   o_mem_r_addr, o_mem_r_en  memory read port (combinational pass-through)
//   o_mem_w_addr/_data/_en    memory write port
//   o_state                   FSM state (IDLE/LOAD/LOADED/RUN)
//   o_word_count              words written in the last or current load
//   o_load_done               one-cycle pulse with the final write
//   o_checksum                (optional) XOR of words written this load
//   o_cpu_stall               CPU must hold its PC
module instr_mem_loader
  import instr_mem_pkg::*;
#(
  parameter int unsigned            NB_DATA_BUS = 32,
  parameter int unsigned            N_ADDRESS   = 64,
  parameter int unsigned            NB_ADDRESS  = $clog2(N_ADDRESS),
  parameter logic [NB_DATA_BUS-1:0] HALT_WORD   = NB_DATA_BUS'(HALT_WORD_DEFAULT)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_load_start,
  input  logic                   i_run,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_valid,
  input  logic [NB_ADDRESS-1:0]  i_cpu_addr,
  input  logic                   i_cpu_r_en,
  output logic [NB_ADDRESS-1:0]  o_mem_r_addr,
  output logic                   o_mem_r_en,
  output logic [NB_ADDRESS-1:0]  o_mem_w_addr,
  output logic [NB_DATA_BUS-1:0] o_mem_w_data,
  output logic                   o_mem_w_en,
  output logic [1:0]             o_state,
  output logic [NB_ADDRESS:0]    o_word_count,
  output logic                   o_load_done,
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
  output logic [NB_DATA_BUS-1:0] o_checksum,
`endif
  output logic                   o_cpu_stall
);

  localparam logic [NB_ADDRESS-1:0] LAST_ADDR = NB_ADDRESS'(N_ADDRESS - 1);

  state_t                 r_state;
  state_t                 w_next_state;
  logic [NB_ADDRESS-1:0]  r_w_addr;
  logic [NB_ADDRESS:0]    r_word_count;
  logic [NB_DATA_BUS-1:0] w_word;
  logic                   w_word_valid;
  logic                   w_wr;
  logic                   w_last_write;
  logic                   w_byte_accept;

  // A restart in the same cycle as a completed word discards that word too.
  assign w_wr         = w_word_valid && (r_state == LOAD) && !i_load_start;
  assign w_last_write = w_wr && ((w_word == HALT_WORD) || (r_w_addr == LAST_ADDR));
  // Bytes arriving alongside the final write belong to no load.
  assign w_byte_accept = i_rx_valid && (r_state == LOAD) && !w_last_write;

  byte_word_assembler #(
    .NB_DATA_BUS(NB_DATA_BUS)
  ) u_assembler (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (i_load_start),
    .i_byte_valid(w_byte_accept),
    .i_byte      (i_rx_data),
    .o_word      (w_word),
    .o_word_valid(w_word_valid)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_w_addr     <= '0;
      r_word_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (i_load_start) begin
        r_w_addr     <= '0;
        r_word_count <= '0;
      end else if (w_wr) begin
        r_word_count <= r_word_count + (NB_ADDRESS + 1)'(1);
        if (r_w_addr != LAST_ADDR) begin
          r_w_addr <= r_w_addr + NB_ADDRESS'(1);
        end
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:   if (i_load_start) w_next_state = LOAD;
      LOAD:   if (i_load_start) w_next_state = LOAD;
              else if (w_last_write) w_next_state = LOADED;
      LOADED: if (i_load_start) w_next_state = LOAD;
              else if (i_run) w_next_state = RUN;
      RUN:    if (i_load_start) w_next_state = LOAD;
      default: w_next_state = IDLE;
    endcase
  end

`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
  logic [NB_DATA_BUS-1:0] r_checksum;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_load_start) begin
      r_checksum <= '0;
    end else if (w_wr) begin
      r_checksum <= r_checksum ^ w_word;
    end
  end

  assign o_checksum = r_checksum;
`endif

  assign o_mem_r_addr = i_cpu_addr;
  assign o_mem_r_en   = i_cpu_r_en && (r_state == RUN);
  assign o_mem_w_addr = r_w_addr;
  assign o_mem_w_data = w_word;
  assign o_mem_w_en   = w_wr;
  assign o_state      = r_state;
  assign o_word_count = r_word_count;
  assign o_load_done  = w_last_write;
  assign o_cpu_stall  = (r_state != RUN);

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

  localparam int          N    = 64;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        i_clk = 1'b0;
  logic        i_rst, i_load_start, i_run, i_rx_valid, i_cpu_r_en;
  logic [7:0]  i_rx_data;
  logic [5:0]  i_cpu_addr;
  logic [5:0]  o_mem_r_addr, o_mem_w_addr;
  logic        o_mem_r_en, o_mem_w_en, o_load_done, o_cpu_stall;
  logic [31:0] o_mem_w_data;
  logic [1:0]  o_state;
  logic [6:0]  o_word_count;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
  logic [31:0] o_checksum;
`endif

  instr_mem_loader #(
    .NB_DATA_BUS(32),
    .N_ADDRESS  (64),
    .NB_ADDRESS (6),
    .HALT_WORD  (32'hFFFF_FFFF)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load_start(i_load_start),
    .i_run       (i_run),
    .i_rx_data   (i_rx_data),
    .i_rx_valid  (i_rx_valid),
    .i_cpu_addr  (i_cpu_addr),
    .i_cpu_r_en  (i_cpu_r_en),
    .o_mem_r_addr(o_mem_r_addr),
    .o_mem_r_en  (o_mem_r_en),
    .o_mem_w_addr(o_mem_w_addr),
    .o_mem_w_data(o_mem_w_data),
    .o_mem_w_en  (o_mem_w_en),
    .o_state     (o_state),
    .o_word_count(o_word_count),
    .o_load_done (o_load_done),
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    .o_checksum  (o_checksum),
`endif
    .o_cpu_stall (o_cpu_stall)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: bytes collected in a queue, a finished word waits one
  // cycle before it is written.
  int          m_state = 0;
  logic [7:0]  m_bytes[$];
  bit          m_pend = 0;
  logic [31:0] m_pend_word = '0;
  int          m_addr = 0;
  int          m_count = 0;
  logic [31:0] m_csum = '0;

  // Samples taken mid-cycle and running observations of the write port.
  logic [31:0] s_state, s_wen, s_waddr, s_wdata, s_count, s_done, s_ren, s_raddr, s_stall, s_csum;
  int          g_wen_cnt, g_done_cnt;
  logic [31:0] g_first_waddr, g_first_wdata, g_last_waddr, g_last_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, ls, run, rv, input logic [7:0] rd,
                            input logic e_wen, e_last);
    bit np;
    np = 0;
    if (rst) begin
      m_state = 0; m_bytes.delete(); m_pend = 0; m_addr = 0; m_count = 0; m_csum = '0;
    end else if (ls) begin
      m_state = 1; m_bytes.delete(); m_pend = 0; m_addr = 0; m_count = 0; m_csum = '0;
    end else begin
      if (e_wen) begin
        m_count++;
        m_csum ^= m_pend_word;
        if (m_addr < N - 1) m_addr++;
      end
      if (m_state == 1 && rv && !e_last) begin
        m_bytes.push_back(rd);
        if (m_bytes.size() == 4) begin
          m_pend_word = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
          np = 1;
          m_bytes.delete();
        end
      end
      if (e_last) m_state = 2;
      else if (m_state == 2 && run) m_state = 3;
      m_pend = np;
    end
  endtask

  task automatic cyc(input logic rst, ls, run, rv, input logic [7:0] rd,
                     input logic ren, input logic [5:0] ra, input bit mchk);
    logic e_wen, e_last;
    i_rst = rst; i_load_start = ls; i_run = run; i_rx_valid = rv; i_rx_data = rd;
    i_cpu_r_en = ren; i_cpu_addr = ra;
    e_wen  = m_pend && (m_state == 1) && !ls;
    e_last = e_wen && ((m_pend_word == HALT) || (m_addr == N - 1));
    @(negedge i_clk);
    s_state = 32'(o_state);      s_wen   = 32'(o_mem_w_en);   s_waddr = 32'(o_mem_w_addr);
    s_wdata = o_mem_w_data;      s_count = 32'(o_word_count); s_done  = 32'(o_load_done);
    s_ren   = 32'(o_mem_r_en);   s_raddr = 32'(o_mem_r_addr); s_stall = 32'(o_cpu_stall);
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    s_csum = o_checksum;
`else
    s_csum = '0;
`endif
    if (o_mem_w_en === 1'b1) begin
      if (g_wen_cnt == 0) begin g_first_waddr = s_waddr; g_first_wdata = s_wdata; end
      g_wen_cnt++;
      g_last_waddr = s_waddr; g_last_wdata = s_wdata;
    end
    if (o_load_done === 1'b1) g_done_cnt++;
    if (mchk) begin
      chk("state", s_state, 32'(m_state));
      chk("w_en", s_wen, 32'(e_wen));
      chk("w_addr", s_waddr, 32'(m_addr));
      if (e_wen) chk("w_data", s_wdata, m_pend_word);
      chk("word_count", s_count, 32'(m_count));
      chk("load_done", s_done, 32'(e_last));
      chk("r_en", s_ren, 32'(ren && (m_state == 3)));
      chk("r_addr", s_raddr, 32'(ra));
      chk("cpu_stall", s_stall, 32'(m_state != 3));
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
      chk("checksum", s_csum, m_csum);
`endif
    end
    model_step(rst, ls, run, rv, rd, e_wen, e_last);
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input bit mchk);
    cyc(0, 0, 0, 0, 8'h00, 0, 6'd0, mchk);
  endtask

  task automatic send(input logic [7:0] b);
    cyc(0, 0, 0, 1, b, 0, 6'd0, 1);
  endtask

  typedef struct {
    logic rst, ls, run, rv; logic [7:0] rd; logic ren; logic [5:0] ra; bit chk;
    logic [1:0] st; logic wen; logic [5:0] waddr; logic [31:0] wdata;
    logic [6:0] cnt; logic done, rren, stall;
  } vec_t;

  vec_t vt[18];

  initial begin
    //        rst ls run rv  rd    ren ra  chk  st wen wa  wdata          cnt done rren stall
    vt[0]  = '{1, 0, 0, 0, 8'h00, 0, 0,  0,  0, 0, 0, 32'h0,          0, 0, 0, 1};
    vt[1]  = '{0, 0, 0, 0, 8'h00, 1, 5,  1,  0, 0, 0, 32'h0,          0, 0, 0, 1};
    vt[2]  = '{0, 1, 0, 0, 8'h00, 0, 0,  1,  0, 0, 0, 32'h0,          0, 0, 0, 1};
    vt[3]  = '{0, 0, 0, 1, 8'h01, 0, 0,  1,  1, 0, 0, 32'h0,          0, 0, 0, 1};
    vt[4]  = '{0, 0, 0, 1, 8'h02, 0, 0,  1,  1, 0, 0, 32'h0,          0, 0, 0, 1};
    vt[5]  = '{0, 0, 0, 1, 8'h03, 0, 0,  1,  1, 0, 0, 32'h0,          0, 0, 0, 1};
    vt[6]  = '{0, 0, 0, 1, 8'h04, 0, 0,  1,  1, 0, 0, 32'h0,          0, 0, 0, 1};
    vt[7]  = '{0, 0, 0, 1, 8'hFF, 0, 0,  1,  1, 1, 0, 32'h04030201,   0, 0, 0, 1};
    vt[8]  = '{0, 0, 0, 1, 8'hFF, 0, 0,  1,  1, 0, 1, 32'h04030201,   1, 0, 0, 1};
    vt[9]  = '{0, 0, 0, 1, 8'hFF, 0, 0,  1,  1, 0, 1, 32'h04030201,   1, 0, 0, 1};
    vt[10] = '{0, 0, 0, 1, 8'hFF, 0, 0,  1,  1, 0, 1, 32'h04030201,   1, 0, 0, 1};
    vt[11] = '{0, 0, 0, 0, 8'h00, 0, 0,  1,  1, 1, 1, 32'hFFFFFFFF,   1, 1, 0, 1};
    vt[12] = '{0, 0, 0, 0, 8'h00, 0, 0,  1,  2, 0, 2, 32'hFFFFFFFF,   2, 0, 0, 1};
    vt[13] = '{0, 0, 0, 0, 8'h00, 1, 5,  1,  2, 0, 2, 32'hFFFFFFFF,   2, 0, 0, 1};
    vt[14] = '{0, 0, 1, 0, 8'h00, 0, 0,  1,  2, 0, 2, 32'hFFFFFFFF,   2, 0, 0, 1};
    vt[15] = '{0, 0, 0, 0, 8'h00, 1, 5,  1,  3, 0, 2, 32'hFFFFFFFF,   2, 0, 1, 0};
    vt[16] = '{0, 0, 0, 1, 8'h55, 0, 0,  1,  3, 0, 2, 32'hFFFFFFFF,   2, 0, 0, 0};
    vt[17] = '{0, 0, 0, 0, 8'h00, 1, 63, 1,  3, 0, 2, 32'hFFFFFFFF,   2, 0, 1, 0};

    i_rst = 0; i_load_start = 0; i_run = 0; i_rx_valid = 0; i_rx_data = '0;
    i_cpu_r_en = 0; i_cpu_addr = '0;
    g_wen_cnt = 0; g_done_cnt = 0;
    @(posedge i_clk);
    #1;

    // Table: reset state, little-endian assembly, halt, LOADED/RUN handoff.
    for (int i = 0; i < 18; i++) begin
      cyc(vt[i].rst, vt[i].ls, vt[i].run, vt[i].rv, vt[i].rd, vt[i].ren, vt[i].ra, 0);
      if (vt[i].chk) begin
        chk($sformatf("t%0d state", i), s_state, 32'(vt[i].st));
        chk($sformatf("t%0d w_en", i), s_wen, 32'(vt[i].wen));
        chk($sformatf("t%0d w_addr", i), s_waddr, 32'(vt[i].waddr));
        chk($sformatf("t%0d w_data", i), s_wdata, vt[i].wdata);
        chk($sformatf("t%0d count", i), s_count, 32'(vt[i].cnt));
        chk($sformatf("t%0d done", i), s_done, 32'(vt[i].done));
        chk($sformatf("t%0d r_en", i), s_ren, 32'(vt[i].rren));
        chk($sformatf("t%0d r_addr", i), s_raddr, 32'(vt[i].ra));
        chk($sformatf("t%0d stall", i), s_stall, 32'(vt[i].stall));
      end
    end
    chk("table writes", 32'(g_wen_cnt), 32'd2);
    chk("table done pulses", 32'(g_done_cnt), 32'd1);

    // Fill to the memory boundary, then extra bytes must not write.
    cyc(0, 1, 0, 0, 8'h00, 0, 6'd0, 1);
    g_wen_cnt = 0; g_done_cnt = 0;
    for (int i = 0; i < 256; i++) send(8'(i) & 8'h7F);
    send(8'hAA);
    for (int i = 0; i < 3; i++) send(8'hAB);
    idle(1);
    chk("full writes", 32'(g_wen_cnt), 32'd64);
    chk("full last addr", g_last_waddr, 32'd63);
    chk("full last data", g_last_wdata, 32'h7F7E7D7C);
    chk("full done pulses", 32'(g_done_cnt), 32'd1);
    chk("full count", s_count, 32'd64);
    chk("full state", s_state, 32'd2);
    chk("full w_addr held", s_waddr, 32'd63);

    // Load start and run together while LOADED: load wins.
    cyc(0, 1, 1, 0, 8'h00, 0, 6'd0, 1);
    idle(1);
    chk("prio state", s_state, 32'd1);
    chk("prio stall", s_stall, 32'd1);

    // Read gating: blocked in LOADED, passed through in RUN.
    for (int i = 0; i < 4; i++) send(8'hFF);
    idle(1); idle(1);
    cyc(0, 0, 0, 0, 8'h00, 1, 6'd5, 1);
    chk("loaded r_en", s_ren, 32'd0);
    cyc(0, 0, 1, 0, 8'h00, 0, 6'd0, 1);
    cyc(0, 0, 0, 0, 8'h00, 1, 6'd5, 1);
    chk("run r_en", s_ren, 32'd1);
    chk("run r_addr", s_raddr, 32'd5);

    // Reset mid-word, then a clean reload.
    cyc(0, 1, 0, 0, 8'h00, 0, 6'd0, 1);
    send(8'hAA); send(8'hBB);
    cyc(1, 0, 0, 1, 8'hCC, 0, 6'd0, 1);
    cyc(0, 0, 0, 1, 8'hDD, 1, 6'd7, 1);
    chk("rst state", s_state, 32'd0);
    chk("rst count", s_count, 32'd0);
    chk("rst w_data", s_wdata, 32'd0);
    chk("rst w_addr", s_waddr, 32'd0);
    chk("rst r_en", s_ren, 32'd0);
    chk("rst stall", s_stall, 32'd1);
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    chk("rst checksum", s_csum, 32'd0);
`endif
    cyc(0, 1, 0, 0, 8'h00, 0, 6'd0, 1);
    g_wen_cnt = 0;
    send(8'h04); send(8'h00); send(8'h00); send(8'h00);
    for (int i = 0; i < 4; i++) send(8'hFF);
    idle(1); idle(1);
    chk("reload addr", g_first_waddr, 32'd0);
    chk("reload data", g_first_wdata, 32'h00000004);
    chk("reload writes", 32'(g_wen_cnt), 32'd2);
    chk("reload count", s_count, 32'd2);

`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    cyc(0, 1, 0, 0, 8'h00, 0, 6'd0, 1);
    send(8'h0F); send(8'h00); send(8'h00); send(8'h00);
    for (int i = 0; i < 4; i++) send(8'hFF);
    idle(1); idle(1);
    chk("checksum value", s_csum, 32'hFFFFFFF0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      logic rst, ls, run, rv, ren;
      logic [7:0] rd;
      logic [5:0] ra;
      rst = ($urandom_range(0, 299) == 0);
      ls  = ($urandom_range(0, 59) == 0);
      run = ($urandom_range(0, 7) == 0);
      rv  = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      ren = 1'($urandom);
      ra  = 6'($urandom);
      cyc(rst, ls, run, rv, rd, ren, ra, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter NB_DATA_BUS, default 32, instruction word width.
REQ-002 SHALL have parameter N_ADDRESS, default 64, instruction memory depth in words.
REQ-003 SHALL have parameter NB_ADDRESS, default $clog2(N_ADDRESS), word address width.
REQ-004 SHALL have parameter HALT_WORD, default 32'hFFFF_FFFF, end-of-program marker.
REQ-005 SHALL have a single clock and a synchronous, active-high reset:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have the following ports:
- i_load_start  in  1  pulse; begin program load.
- i_run  in  1  pulse; release CPU fetch.
- i_rx_data  in  8  program byte from the debug serial link.
- i_rx_valid  in  1  i_rx_data valid this cycle.
- i_cpu_addr  in  NB_ADDRESS  CPU fetch word address.
- i_cpu_r_en  in  1  CPU fetch request.
- o_mem_r_addr  out  NB_ADDRESS  memory read address.
- o_mem_r_en  out  1  memory read enable.
- o_mem_w_addr  out  NB_ADDRESS  memory write address.
- o_mem_w_data  out  NB_DATA_BUS  memory write data.
- o_mem_w_en  out  1  memory write strobe.
- o_state  out  2  FSM state.
- o_word_count  out  NB_ADDRESS+1  words written in the last or current load.
- o_load_done  out  1  one-cycle pulse when a load completes.
- o_cpu_stall  out  1  CPU must hold its PC.

Function
REQ-007 SHALL implement FSM states IDLE=0, LOAD=1, LOADED=2, RUN=3, driven on o_state.
REQ-008 SHALL transition as follows:
- IDLE -> LOAD on i_load_start.
- LOAD -> LOADED on a HALT_WORD write or a write to address N_ADDRESS-1.
- LOADED -> RUN on i_run.
- LOADED or RUN -> LOAD on i_load_start.
- All other inputs hold the current state.
REQ-009 SHALL give i_load_start priority when i_load_start and i_run assert in the same cycle.
REQ-010 SHALL, on entry to LOAD, clear the byte index, the write address and o_word_count.
REQ-011 SHALL, in LOAD, accept one byte per cycle with i_rx_valid high, assembling little-endian (first byte -> bits 7:0, fourth -> bits 31:24).
REQ-012 SHALL, one cycle after the fourth byte, pulse o_mem_w_en for exactly one cycle.
- o_mem_w_addr = current word address; o_mem_w_data = assembled word.
- Word address and o_word_count then increment.
REQ-013 SHALL write HALT_WORD to memory and count it before entering LOADED; o_load_done pulses in the same cycle as that write.
REQ-014 SHALL stop at the memory boundary: a write to address N_ADDRESS-1 enters LOADED with o_word_count=N_ADDRESS, the address never wraps, and o_load_done pulses.
REQ-015 SHALL ignore i_rx_valid outside LOAD, and ignore bytes that arrive in the cycle the final write issues.
REQ-016 SHALL, on i_load_start during LOAD, restart the load at address 0 and discard any partial word.
REQ-017 SHALL drive o_mem_r_en = i_cpu_r_en AND (state==RUN), and o_mem_r_addr = i_cpu_addr, combinationally, so the memory samples them on its falling-edge read.
REQ-018 SHALL drive o_cpu_stall = 1 in every state except RUN.
REQ-019 SHALL never assert o_mem_w_en outside LOAD.

Reset
REQ-020 SHALL, on i_rst, enter IDLE and clear all counters.
- Outputs: o_mem_w_en=0, o_mem_r_en=0, o_mem_w_addr=0, o_mem_w_data=0, o_word_count=0, o_load_done=0, o_cpu_stall=1, o_checksum=0.
REQ-021 SHALL abort any load mid-word on i_rst; memory contents are not cleared.

Configuration
REQ-022 SHALL, with macro INSTR_MEM_LOADER_CHECKSUM_EN defined:
- Add output o_checksum (NB_DATA_BUS), the XOR of all words written in the current load, HALT_WORD included.
- Clear o_checksum on LOAD entry and on reset.
REQ-023 SHALL, without INSTR_MEM_LOADER_CHECKSUM_EN, omit the o_checksum port and its logic entirely.

Structure
REQ-024 SHALL place the state encodings IDLE/LOAD/LOADED/RUN and the default HALT_WORD constant in shared package instr_mem_pkg.
REQ-025 SHALL implement byte-to-word assembly in one sub-module, byte_word_assembler (byte index, shift register, word-valid pulse).

Verification
REQ-026 SHALL cover the following directed scenarios:
- Load 8 bytes 01 02 03 04 FF FF FF FF -> writes 32'h04030201 at addr 0 and HALT_WORD at addr 1; o_word_count=2; o_load_done pulses once; state=LOADED.
- Load 4*64 non-halt bytes -> 64 writes, last at addr 63; o_word_count=64; state=LOADED; a 257th byte produces no write.
- i_load_start and i_run in the same cycle while LOADED -> state=LOAD; o_cpu_stall stays 1.
- In RUN, i_cpu_r_en=1 with i_cpu_addr=5 -> o_mem_r_en=1, o_mem_r_addr=5; with the same request in LOADED -> o_mem_r_en=0.
- i_rst after 2 bytes of a word, then reload of 04 00 00 00 FF FF FF FF -> addr 0 = 32'h00000004 with no stale bytes.
- With INSTR_MEM_LOADER_CHECKSUM_EN, load 32'h0000000F then HALT_WORD -> o_checksum=32'hFFFFFFF0.
